// File: rtl/demux_pkg.sv
// demux_pkg
//   Shared definitions for the 1-to-4 demultiplexer and its 7-segment
//   index display.
//   - NCH        : number of output channels
//   - ch_idx_t   : 2-bit channel index
//   - SEG_*      : active-low {dp,g,f,e,d,c,b,a} patterns for blank and 0..3
package demux_pkg;

  localparam int NCH = 4;

  typedef logic [1:0] ch_idx_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_D0    = 8'hC0;
  localparam logic [7:0] SEG_D1    = 8'hF9;
  localparam logic [7:0] SEG_D2    = 8'hA4;
  localparam logic [7:0] SEG_D3    = 8'hB0;

endpackage

// File: rtl/seg7_idx_dec.sv
// seg7_idx_dec
//   Combinational decoder from a 2-bit channel index to an 8-bit active-low
//   7-segment pattern {dp,g,f,e,d,c,b,a}. The decimal point is always off.
// Ports:
//   i_idx : channel index 0..3
//   o_seg : active-low segment pattern
module seg7_idx_dec
  import demux_pkg::*;
(
  input  ch_idx_t    i_idx,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_idx)
      2'd0:    o_seg = SEG_D0;
      2'd1:    o_seg = SEG_D1;
      2'd2:    o_seg = SEG_D2;
      2'd3:    o_seg = SEG_D3;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/demux14_2bit.sv
// demux14_2bit
//   Registered 1-to-4 demultiplexer. One W-bit valid/ready input stream is
//   steered into one of four single-entry holding slots; each slot is drained
//   by its own acknowledge. The 7-segment digit shows the last channel written.
//
//   Optional feature (macro DEMUX_RR_EN): when defined, auto_mode=1 targets a
//   round-robin pointer that advances on every accepted transfer made in auto
//   mode. When undefined, auto_mode is ignored and the target is always sel.
//
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   din        : input data word (W bits)
//   din_valid  : din holds a word to transfer
//   din_ready  : block can accept din this cycle (combinational)
//   sel        : target channel when not in auto mode
//   auto_mode  : request round-robin targeting
//   Q0..Q3     : slot data registers
//   q_full     : bit i set when slot i holds unconsumed data
//   q_ack      : bit i drains slot i this cycle (ignored when empty)
//   seg0       : active-low 7-segment pattern of last written channel
module demux14_2bit
  import demux_pkg::*;
#(
  parameter int W = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  output logic           din_ready,
  input  logic [1:0]     sel,
  input  logic           auto_mode,
  output logic [W-1:0]   Q0,
  output logic [W-1:0]   Q1,
  output logic [W-1:0]   Q2,
  output logic [W-1:0]   Q3,
  output logic [NCH-1:0] q_full,
  input  logic [NCH-1:0] q_ack,
  output logic [7:0]     seg0
);

  logic [W-1:0]   r_q [NCH];
  logic [NCH-1:0] r_full;
  logic [7:0]     r_seg;

  ch_idx_t        w_tgt;
  ch_idx_t        w_rr_ptr;
  logic           w_auto_eff;
  logic           w_xfer;
  logic [NCH-1:0] w_wr;
  logic [NCH-1:0] w_full_nxt;
  logic [7:0]     w_seg;

`ifdef DEMUX_RR_EN
  ch_idx_t r_rr_ptr;

  assign w_auto_eff = auto_mode;
  assign w_rr_ptr   = r_rr_ptr;

  // Pointer only moves on a transfer it actually targeted; a stall on a full
  // slot holds it, so no channel is ever skipped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
    end else if (w_xfer && w_auto_eff) begin
      r_rr_ptr <= r_rr_ptr + 2'd1;
    end
  end
`else
  // Round-robin support is compiled out: auto_mode is tied off here so the
  // target mux below folds down to sel.
  assign w_auto_eff = auto_mode & 1'b0;
  assign w_rr_ptr   = '0;
`endif

  assign w_tgt = w_auto_eff ? w_rr_ptr : ch_idx_t'(sel);

  // A full target slot can still accept when its consumer drains it this
  // same cycle.
  assign din_ready = ~r_full[w_tgt] | q_ack[w_tgt];
  assign w_xfer    = din_valid & din_ready;

  always_comb begin
    w_wr        = '0;
    w_wr[w_tgt] = w_xfer;
  end

  // A write wins over a coincident ack on the same slot; acks on empty
  // slots fall out naturally since r_full is already 0.
  assign w_full_nxt = w_wr | (r_full & ~q_ack);

  seg7_idx_dec u_seg_dec (
    .i_idx (w_tgt),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_q[i] <= '0;
      end
      r_full <= '0;
      r_seg  <= SEG_BLANK;
    end else begin
      // Drained slots keep their data; only a write updates a slot.
      for (int i = 0; i < NCH; i++) begin
        if (w_wr[i]) begin
          r_q[i] <= din;
        end
      end
      r_full <= w_full_nxt;
      if (w_xfer) begin
        r_seg <= w_seg;
      end
    end
  end

  assign Q0     = r_q[0];
  assign Q1     = r_q[1];
  assign Q2     = r_q[2];
  assign Q3     = r_q[3];
  assign q_full = r_full;
  assign seg0   = r_seg;

endmodule

// File: doc/demux14_2bit.md
Name: demux14_2bit

Overview:
- Registered 1-to-4 demultiplexer: the inverse of the 4-to-1 2-bit keyed selector already on the board.
- Accepts one W-bit input stream with a valid/ready handshake and steers each accepted word into one of four single-entry output holding slots.
- Each slot is drained independently by its own acknowledge.
- Drives the board's 7-segment digit with the index of the last channel written.

Parameters:
- W, 2, data width of input word and of each output slot.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; one clock; reset is asynchronous and active-high.
- din  input  W  input data word.
- din_valid  input  1  din holds a word to transfer.
- din_ready  output  1  block can accept din this cycle.
- sel  input  2  target channel index (0..3), used when not in auto mode.
- auto_mode  input  1  request round-robin targeting (effective only with DEMUX_RR_EN).
- Q0, Q1, Q2, Q3  output  W each  slot data registers.
- q_full  output  4  bit i set: slot i holds unconsumed data.
- q_ack  input  4  bit i: consumer of slot i takes data this cycle (ignored if q_full[i]=0).
- seg0  output  8  active-low {dp,g,f,e,d,c,b,a}; last written channel index.

Behaviour:
- Reset (async assert, sync-released domain): Q0..Q3=0, q_full=0, RR pointer=0, seg0=8'hFF (blank).
- Target t: sel, or RR pointer when auto mode is effective.
- Readiness: din_ready = ~q_full[t] | q_ack[t] (combinational). Same-cycle drain and refill of slot t is allowed.
- Transfer: occurs when din_valid & din_ready.
  - Next edge: Q[t]<=din, q_full[t]<=1, seg0<=digit(t).
  - Latency: 1 cycle, din to Q[t]/q_full[t].
- Drain: q_ack[i] & q_full[i] & not being written this cycle -> q_full[i]<=0. Q[i] retains its value (not cleared).
- Simultaneous ack and write on same slot: q_full stays 1, Q takes the new din.
- Acks on other slots are independent and may coincide with the write.
- din_valid with din_ready=0: no state change. The producer holds din/sel stable until accepted; the block does not enforce this.
- q_ack on an empty slot: no effect.
- digit() encoding: 0->C0, 1->F9, 2->A4, 3->B0 (hex). dp is always off.
- seg0 changes only on a transfer.
- Reset mid-transfer: all slots are lost immediately and din_ready reflects empty slots (1) after release.

Optional Feature:
- Macro: DEMUX_RR_EN.
- Defined:
  - auto_mode=1 selects the 2-bit RR pointer as target.
  - The pointer increments mod 4 (3->0 wrap) on each accepted transfer while auto_mode=1.
  - Pointer holds when auto_mode=0.
  - If the pointed slot is full and not acked, the block stalls. It never skips a channel.
- Undefined: auto_mode is ignored, there is no pointer register, and the target is always sel.

Decomposition:
- Shared package demux_pkg:
  - localparam NCH=4.
  - 2-bit channel index typedef.
  - Segment constants SEG_BLANK=8'hFF, SEG_D0..SEG_D3.
- One sub-module: seg7_idx_dec, a combinational 2-bit index to 8-bit active-low pattern decoder, reusable by other display blocks.

Test Plan:
- Reset: assert rst mid-cycle -> immediately q_full=0000, Q*=0, seg0=FF, din_ready=1.
- Directed write: sel=2, din=2'b11, valid 1 cycle -> next edge Q2=3, q_full=0100, seg0=A4; other slots unchanged.
- Backpressure: slot 1 full, sel=1, valid held, q_ack=0 -> din_ready=0 for 3 cycles with no change. Then q_ack[1]=1 -> same cycle ready=1, next edge Q1=new din, q_full[1] stays 1.
- Drain only: q_ack=1111 with q_full=1010, valid=0 -> q_full=0000, Q values retained.
- RR (DEMUX_RR_EN): auto_mode=1, send 5 words 0,1,2,3,0 with all slots acked -> written to ch0,1,2,3,0; seg0 sequence C0,F9,A4,B0,C0.
- RR stall: slot 2 full and unacked, pointer=2 -> ready=0, pointer stays 2, no write lands in slot 3.
